// File: rtl/md_unit.sv
// Multiply/divide unit owning the HI/LO pair; one op per start, result commits after a fixed latency.
// Optional accumulate ops (madd/maddu/msub/msubu) are built only when MDU_MADD_EN is defined.
module md_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int unsigned DW         = 2 * WIDTH;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_pend_hi;
    logic [WIDTH-1:0]   r_pend_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   w_pend_hi_nxt;
    logic [WIDTH-1:0]   w_pend_lo_nxt;
    logic [WIDTH-1:0]   w_hi_nxt;
    logic [WIDTH-1:0]   w_lo_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    // Operation decode
    logic               w_is_div;
    logic               w_unsigned;
    logic               w_op_ok;
    logic               w_last;
    logic               w_can_accept;
    logic               w_accept;

    assign w_is_div   = op[1] & ~op[2];
    assign w_unsigned = op[0];

    // Full-width product; extending to 2*WIDTH makes the low half correct for both signednesses
    logic [DW-1:0]      w_ext_a;
    logic [DW-1:0]      w_ext_b;
    logic [DW-1:0]      w_prod;

    assign w_ext_a = w_unsigned ? {{WIDTH{1'b0}}, a} : {{WIDTH{a[WIDTH-1]}}, a};
    assign w_ext_b = w_unsigned ? {{WIDTH{1'b0}}, b} : {{WIDTH{b[WIDTH-1]}}, b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Sign-magnitude divide; most-negative / -1 falls out as quotient 2^(W-1), remainder 0
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_divisor;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [DW-1:0]      w_div_res;

    assign w_a_neg   = ~w_unsigned & a[WIDTH-1];
    assign w_b_neg   = ~w_unsigned & b[WIDTH-1];
    assign w_b_zero  = (b == '0);
    assign w_a_mag   = w_a_neg ? -a : a;
    assign w_b_mag   = w_b_neg ? -b : b;
    assign w_divisor = w_b_zero ? WIDTH'(1) : w_b_mag;
    assign w_q_mag   = w_a_mag / w_divisor;
    assign w_r_mag   = w_a_mag % w_divisor;
    assign w_quo     = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    assign w_rem     = w_a_neg ? -w_r_mag : w_r_mag;
    assign w_div_res = w_b_zero ? {a, {WIDTH{1'b1}}} : {w_rem, w_quo};

    logic [DW-1:0]      w_mul_res;
    logic [DW-1:0]      w_result;

`ifdef MDU_MADD_EN
    logic               w_is_msub;
    logic [DW-1:0]      w_acc_src;
    logic [DW-1:0]      w_acc_res;

    // A start accepted on the commit edge must accumulate onto the result being committed
    assign w_is_msub = op[2] & op[1];
    assign w_acc_src = (r_state == S_RUN) ? {r_pend_hi, r_pend_lo} : {r_hi, r_lo};
    assign w_acc_res = w_is_msub ? (w_acc_src - w_prod) : (w_acc_src + w_prod);
    assign w_mul_res = op[2] ? w_acc_res : w_prod;
    assign w_op_ok   = 1'b1;
`else
    assign w_mul_res = w_prod;
    assign w_op_ok   = ~op[2];
`endif

    assign w_result     = w_is_div ? w_div_res : w_mul_res;
    assign w_last       = (r_cnt <= CNT_W'(1));
    assign w_can_accept = (r_state == S_IDLE) | ((r_state == S_RUN) & w_last);
    assign w_accept     = start & w_op_ok & w_can_accept;

    // Next-state and datapath update
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (!w_accept) begin
                    if (wr_hi) w_hi_nxt = wdata;
                    if (wr_lo) w_lo_nxt = wdata;
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (w_last) begin
                    w_hi_nxt    = r_pend_hi;
                    w_lo_nxt    = r_pend_lo;
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
        endcase

        if (w_accept) begin
            w_state_nxt   = S_RUN;
            w_busy_nxt    = 1'b1;
            w_cnt_nxt     = w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            w_pend_hi_nxt = w_result[DW-1:WIDTH];
            w_pend_lo_nxt = w_result[WIDTH-1:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: driver pushes model results, monitor checks each done pulse.
// Accumulate ops are expected to work only when MDU_MADD_EN is defined.
module tb_md_unit;

    localparam int unsigned W  = 32;
    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic           clk;
    logic           reset;
    logic           start;
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           wr_hi;
    logic           wr_lo;
    logic [W-1:0]   wdata;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic           busy;
    logic           done;

    md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned n;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural reference: new {HI,LO} after one op
    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] h, input logic [31:0] l);
        longint      sp;
        logic [63:0] up;
        logic [63:0] prod;
        int          q;
        int          r;
        sp   = longint'($signed(x)) * longint'($signed(y));
        up   = {32'd0, x} * {32'd0, y};
        prod = o[0] ? up : sp;
        case (o)
            3'd0, 3'd1: return prod;
            3'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            3'd3: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            3'd4, 3'd5: return {h, l} + prod;
            default:    return {h, l} - prod;
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 9));
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: pops one expectation per done pulse and checks the busy window that preceded it
    initial begin
        int unsigned bcnt;
        exp_t        e;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                bcnt = 0;
            end else if (done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 with hi=%h lo=%h, expected no commit", hi, lo);
                end else begin
                    e = sb_q.pop_front();
                    check("commit_hi", 64'(hi), 64'(e.hi));
                    check("commit_lo", 64'(lo), 64'(e.lo));
                    check("busy_cycles", 64'(bcnt), 64'(e.n));
                end
                bcnt = busy ? 1 : 0;
            end else if (busy) begin
                bcnt++;
            end
        end
    end

    task automatic wait_idle();
        int unsigned k;
        k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic mt(input bit h, input bit l, input logic [31:0] v);
        wr_hi = h;
        wr_lo = l;
        wdata = v;
        @(negedge clk);
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        if (h) m_hi = v;
        if (l) m_lo = v;
        check("mt_hi", 64'(hi), 64'(m_hi));
        check("mt_lo", 64'(lo), 64'(m_lo));
    endtask

    // Called just after a negedge when the DUT can accept; chain leaves us one half-cycle before the commit edge
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit chain, input bit poke, output bit chained);
        bit          ok;
        int unsigned n;
        logic [63:0] r;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
`ifdef MDU_MADD_EN
        ok = 1'b1;
`else
        ok = !o[2];
`endif
        n       = (o == 3'd2 || o == 3'd3) ? DC : MC;
        chained = 1'b0;
        start   = 1'b1;
        op      = o;
        a       = x;
        b       = y;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        if (ok) begin
            r = ref_op(o, x, y, m_hi, m_lo);
            sb_q.push_back('{hi: r[63:32], lo: r[31:0], n: n});
            m_hi = r[63:32];
            m_lo = r[31:0];
            if (poke) begin
                old_hi = hi;
                old_lo = lo;
                wr_hi  = 1'b1;
                wr_lo  = 1'b1;
                wdata  = 32'h55;
                @(negedge clk);
                wr_hi = 1'b0;
                wr_lo = 1'b0;
                check("run_hidden_hi", 64'(hi), 64'(old_hi));
                check("run_hidden_lo", 64'(lo), 64'(old_lo));
            end
            if (chain) begin
                repeat (poke ? n - 2 : n - 1) @(negedge clk);
                chained = 1'b1;
            end else begin
                wait_idle();
            end
        end else begin
            check("ignored_busy", 64'(busy), 64'(0));
            check("ignored_hi", 64'(hi), 64'(m_hi));
            check("ignored_lo", 64'(lo), 64'(m_lo));
        end
    endtask

    initial begin
        bit ch;
        bit chained;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        wdata = '0;
        m_hi  = '0;
        m_lo  = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hi", 64'(hi), 64'(0));
        check("reset_lo", 64'(lo), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, chained);
        issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, chained);
        issue(3'd0, 32'd3, 32'd4, 1'b0, 1'b0, chained);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, chained);
        issue(3'd3, 32'h1234, 32'd0, 1'b0, 1'b0, chained);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, chained);
        mt(1'b1, 1'b0, 32'd0);
        mt(1'b0, 1'b1, 32'hFFFF_FFFF);
        issue(3'd4, 32'd1, 32'd1, 1'b0, 1'b0, chained);
        issue(3'd0, 32'd6, 32'd7, 1'b0, 1'b1, chained);
        mt(1'b1, 1'b1, 32'h0BAD_F00D);

        // Reset in the middle of a multiply: nothing may commit
        start = 1'b1;
        op    = 3'd0;
        a     = 32'd3;
        b     = 32'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'(1));
        #2 reset = 1'b0;
        #1;
        check("async_reset_busy", 64'(busy), 64'(0));
        check("async_reset_hi", 64'(hi), 64'(0));
        check("async_reset_lo", 64'(lo), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        m_hi  = '0;
        m_lo  = '0;
        repeat (15) @(negedge clk);
        check("post_reset_hi", 64'(hi), 64'(0));
        check("post_reset_lo", 64'(lo), 64'(0));
        check("post_reset_busy", 64'(busy), 64'(0));

        // Randomised traffic with occasional back-to-back issue
        chained = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (!chained && $urandom_range(0, 4) == 0) begin
                mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom));
            end else begin
                ch = ($urandom_range(0, 2) == 0);
                issue(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), ch, 1'b0, chained);
            end
        end
        wait_idle();
        repeat (3) @(negedge clk);
        check("final_hi", 64'(hi), 64'(m_hi));
        check("final_lo", 64'(lo), 64'(m_lo));
        check("scoreboard_drain", 64'(sb_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
